// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the VC arbiter.
// Contents: FSM state encodings (IDLE=0, RUN=1) and the destination select values DEST_D0/DEST_D1.
// The D-side demux uses the same destination constants.
package vc_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  // Return the almost-full flag of the destination picked by a word's destination bit.
  function automatic logic dest_almost_full(input logic dest, input logic d0_af, input logic d1_af);
    return (dest == DEST_D1) ? d1_af : d0_af;
  endfunction

endpackage

// File: rtl/vc_arbiter_if.sv
// Bus between the VC arbiter and its surrounding FIFOs and flow control.
//
// Handshake rules:
//   - VC side: a first-word-fall-through FIFO presents its head word whenever !vcX_empty.
//     vcX_pop is a combinational accept strobe. The head is consumed at the clock edge
//     that ends a cycle in which vcX_pop=1. vcX_pop is never 1 while vcX_empty=1.
//   - D side: dX_push is a registered write strobe, and data_out is valid whenever it is 1.
//     Almost-full acts as a conservative not-ready. It leaves one free entry for the
//     word already in flight, so the D FIFO never has to push back.
// The 'state' signal exposes the arbiter FSM for debug and monitoring.
interface vc_arbiter_if
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W = 6
);
  logic              active_in;
  logic              vc0_empty;
  logic              vc1_empty;
  logic [DATA_W-1:0] vc0_data;
  logic [DATA_W-1:0] vc1_data;
  logic              d0_almost_f;
  logic              d1_almost_f;
  logic              vc0_pop;
  logic              vc1_pop;
  logic              d0_push;
  logic              d1_push;
  logic [DATA_W-1:0] data_out;
  logic              arb_idle;
  arb_state_e        state;

  // Arbiter side
  modport master (
    input  active_in, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_f, d1_almost_f,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out, arb_idle, state
  );

  // Environment side: the FIFOs and flow control
  modport slave (
    output active_in, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_f, d1_almost_f,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, arb_idle, state
  );
endinterface

// File: rtl/vc_arb_starve_cnt.sv
// Starvation counter for the VC arbiter.
// Counts VC0 grants taken while VC1 waits, and saturates at LIMIT.
// 'hit' tells the arbiter to give the next grant to VC1.
// This module is instantiated only when VC_STARVE_GUARD_EN is defined.
module vc_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturating count of VC0 grants made while VC1 is waiting; any VC1 grant clears it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit = (cnt_q >= CNT_W'(LIMIT));
endmodule

// File: rtl/vc_arbiter.sv
// VC arbiter: moves one word per clock from VC0/VC1 to D0/D1.
// VC0 has strict priority. Each word is routed to a destination by its bit DEST_BIT.
// Optional feature macro: VC_STARVE_GUARD_EN. When it is defined, VC1 is forced
// through after STARVE_LIMIT consecutive VC0 grants made while VC1 was waiting.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W       = 6,
  parameter int DEST_BIT     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  vc_arbiter_if.master  bus
);

  arb_state_e        state_q;
  logic              d0_push_q;
  logic              d1_push_q;
  logic [DATA_W-1:0] data_q;
  logic              idle_q;

  logic vc0_dest;
  logic vc1_dest;
  logic vc0_elig;
  logic vc1_elig;
  logic grant_ok;
  logic starve_hit;
  logic take_vc0;
  logic take_vc1;

  // Eligibility and single-winner grant. VC1 can bypass a VC0 head whose destination is blocked.
  always_comb begin
    vc0_dest = bus.vc0_data[DEST_BIT];
    vc1_dest = bus.vc1_data[DEST_BIT];
    vc0_elig = !bus.vc0_empty && !dest_almost_full(vc0_dest, bus.d0_almost_f, bus.d1_almost_f);
    vc1_elig = !bus.vc1_empty && !dest_almost_full(vc1_dest, bus.d0_almost_f, bus.d1_almost_f);
    grant_ok = !reset && (state_q == ST_RUN) && bus.active_in;
    take_vc1 = grant_ok && vc1_elig && (!vc0_elig || starve_hit);
    take_vc0 = grant_ok && vc0_elig && !take_vc1;
  end

`ifdef VC_STARVE_GUARD_EN
  vc_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (take_vc1 || (state_q == ST_IDLE)),
    .inc   (take_vc0 && vc1_elig),
    .hit   (starve_hit)
  );
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign starve_hit          = 1'b0;
`endif

  // FSM plus registered push, data and idle outputs. A reset drops any push that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      data_q    <= '0;
      idle_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.active_in && (!bus.vc0_empty || !bus.vc1_empty)) state_q <= ST_RUN;
        ST_RUN:  if (!bus.active_in || (bus.vc0_empty && bus.vc1_empty))   state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      d0_push_q <= (take_vc0 && (vc0_dest == DEST_D0)) || (take_vc1 && (vc1_dest == DEST_D0));
      d1_push_q <= (take_vc0 && (vc0_dest == DEST_D1)) || (take_vc1 && (vc1_dest == DEST_D1));
      if (take_vc0) begin
        data_q <= bus.vc0_data;
      end else if (take_vc1) begin
        data_q <= bus.vc1_data;
      end
      idle_q <= (state_q == ST_IDLE) && !d0_push_q && !d1_push_q;
    end
  end

  assign bus.vc0_pop  = take_vc0;
  assign bus.vc1_pop  = take_vc1;
  assign bus.d0_push  = d0_push_q;
  assign bus.d1_push  = d1_push_q;
  assign bus.data_out = data_q;
  assign bus.arb_idle = idle_q;
  assign bus.state    = state_q;
endmodule
